// File: rtl/tlb_lookup_arbiter_pkg.sv
// Shared TLB types: joint-TLB entry layout, page-size codes, arbiter FSM state.
package tlb_lookup_arbiter_pkg;

    localparam logic [1:0] PS4K  = 2'd0;
    localparam logic [1:0] PS16K = 2'd1;
    localparam logic [1:0] PS64K = 2'd2;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [1:0]  ps;
    } tlb_tag_t;

    typedef struct packed {
        tlb_tag_t    tag;
        logic [19:0] pfn0;
        logic [4:0]  flags0;   // {c[2:0], d, v}
        logic [19:0] pfn1;
        logic [4:0]  flags1;
    } TLBEntry;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WRITE
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_sel_t;

    // Larger pages cover more VPN2 values, so their low VPN2 bits are don't-care.
    function automatic logic [18:0] vpn2_mask(input logic [1:0] ps);
        case (ps)
            PS16K:   return 19'h7FFFC;
            PS64K:   return 19'h7FFF0;
            default: return 19'h7FFFF;
        endcase
    endfunction

endpackage

// File: rtl/tlb_lookup_arbiter_group_match.sv
// Combinational tag compare of one entry group; reports the lowest matching slot.
module tlb_group_match
    import tlb_lookup_arbiter_pkg::*;
#(
    parameter  int GROUP_SIZE = 4,
    localparam int SLOT_W     = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1
) (
    input  tlb_tag_t [GROUP_SIZE-1:0] i_tags,
    input  logic [18:0]               i_vpn2,
    input  logic [7:0]                i_asid,
    output logic                      o_hit,
    output logic [SLOT_W-1:0]         o_slot
);

    logic [GROUP_SIZE-1:0] w_match;

    always_comb begin
        w_match = '0;
        for (int k = 0; k < GROUP_SIZE; k++) begin
            w_match[k] = (((i_tags[k].vpn2 ^ i_vpn2) & vpn2_mask(i_tags[k].ps)) == 19'd0)
                         && (i_tags[k].g || (i_tags[k].asid == i_asid));
        end
    end

    // Scan downward so the lowest matching slot is the last one written.
    always_comb begin
        o_hit  = 1'b0;
        o_slot = '0;
        for (int k = GROUP_SIZE - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                o_hit  = 1'b1;
                o_slot = SLOT_W'(k);
            end
        end
    end

endmodule

// File: rtl/tlb_lookup_arbiter.sv
// Arbitrates i/d fast-TLB refill lookups and CP0 writes onto the shared joint-TLB array,
// scanning one group of entries per cycle.
module tlb_lookup_arbiter
    import tlb_lookup_arbiter_pkg::*;
#(
    parameter  int ENTRIES    = 64,
    parameter  int GROUP_SIZE = 4,
    localparam int GROUPS     = ENTRIES / GROUP_SIZE,
    localparam int IDX_W      = $clog2(ENTRIES),
    localparam int GRP_W      = $clog2(GROUPS),
    localparam int SLOT_W     = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_i_valid,
    input  logic [18:0]               i_i_vpn2,
    input  logic [7:0]                i_i_asid,
    output logic                      o_i_ready,
    output logic                      o_i_miss,
    output logic [IDX_W-1:0]          o_i_index,
    output TLBEntry                   o_i_resp,
    input  logic                      i_d_valid,
    input  logic [18:0]               i_d_vpn2,
    input  logic [7:0]                i_d_asid,
    output logic                      o_d_ready,
    output logic                      o_d_miss,
    output logic [IDX_W-1:0]          o_d_index,
    output TLBEntry                   o_d_resp,
    input  logic                      i_cw_req,
    input  logic [IDX_W-1:0]          i_cw_index,
    input  TLBEntry                   i_cw_entry,
    output logic                      o_cw_ack,
    output logic [GRP_W-1:0]          o_g_addr,
    input  TLBEntry [GROUP_SIZE-1:0]  i_g_rdata,
    output logic                      o_a_we,
    output logic [IDX_W-1:0]          o_a_windex,
    output TLBEntry                   o_a_wdata,
    output logic                      o_w_valid,
    output logic [IDX_W-1:0]          o_w_index
);

    arb_state_t  r_state, w_state_nxt;
    req_sel_t    r_owner, r_rr_ptr, w_grant_sel;
    logic [GRP_W-1:0] r_group;
    logic [18:0] r_vpn2, w_owner_vpn2, w_grant_vpn2;
    logic [7:0]  r_asid, w_owner_asid, w_grant_asid;
    logic [IDX_W-1:0] r_cw_index, r_hit_index, w_hit_index;
    TLBEntry     r_cw_entry, r_hit_entry;
    logic        r_i_ready, r_d_ready, r_i_miss, r_d_miss;
    logic        w_owner_valid, w_owner_same;
    logic        w_grant, w_write_go, w_hit_go, w_miss_go;
    logic        w_hit;
    logic [SLOT_W-1:0] w_slot;
    tlb_tag_t [GROUP_SIZE-1:0] w_tags;

    always_comb begin
        for (int k = 0; k < GROUP_SIZE; k++) w_tags[k] = i_g_rdata[k].tag;
    end

    tlb_group_match #(.GROUP_SIZE(GROUP_SIZE)) u_match (
        .i_tags (w_tags),
        .i_vpn2 (r_vpn2),
        .i_asid (r_asid),
        .o_hit  (w_hit),
        .o_slot (w_slot)
    );

    assign w_owner_valid = (r_owner == REQ_D) ? i_d_valid : i_i_valid;
    assign w_owner_vpn2  = (r_owner == REQ_D) ? i_d_vpn2  : i_i_vpn2;
    assign w_owner_asid  = (r_owner == REQ_D) ? i_d_asid  : i_i_asid;
    // A requester that withdraws or changes its lookup mid-scan loses the slot.
    assign w_owner_same  = w_owner_valid && (w_owner_vpn2 == r_vpn2) && (w_owner_asid == r_asid);

    assign w_grant_sel   = (i_i_valid && i_d_valid) ? r_rr_ptr : (i_i_valid ? REQ_I : REQ_D);
    assign w_grant_vpn2  = (w_grant_sel == REQ_D) ? i_d_vpn2 : i_i_vpn2;
    assign w_grant_asid  = (w_grant_sel == REQ_D) ? i_d_asid : i_i_asid;
    assign w_hit_index   = IDX_W'(r_group) * IDX_W'(GROUP_SIZE) + IDX_W'(w_slot);

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_write_go  = 1'b0;
        w_hit_go    = 1'b0;
        w_miss_go   = 1'b0;
        o_g_addr    = '0;
        o_a_we      = 1'b0;
        o_a_windex  = '0;
        o_a_wdata   = '0;
        o_w_valid   = 1'b0;
        o_w_index   = '0;
        o_cw_ack    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cw_req) begin
                    w_state_nxt = ST_WRITE;
                    w_write_go  = 1'b1;
                end else if (i_i_valid || i_d_valid) begin
                    w_state_nxt = ST_SCAN;
                    w_grant     = 1'b1;
                end
            end
            ST_SCAN: begin
                o_g_addr = r_group;
                if (i_cw_req) begin
                    w_state_nxt = ST_WRITE;
                    w_write_go  = 1'b1;
                end else if (!w_owner_same) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_hit) begin
                    w_state_nxt = ST_IDLE;
                    w_hit_go    = 1'b1;
                end else if (r_group == GRP_W'(GROUPS - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_miss_go   = 1'b1;
                end
            end
            ST_WRITE: begin
                o_a_we      = 1'b1;
                o_a_windex  = r_cw_index;
                o_a_wdata   = r_cw_entry;
                o_w_valid   = 1'b1;
                o_w_index   = r_cw_index;
                o_cw_ack    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner     <= REQ_I;
            r_rr_ptr    <= REQ_I;
            r_group     <= '0;
            r_vpn2      <= '0;
            r_asid      <= '0;
            r_cw_index  <= '0;
            r_cw_entry  <= '0;
            r_hit_index <= '0;
            r_hit_entry <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_i_miss    <= 1'b0;
            r_d_miss    <= 1'b0;
        end else begin
            r_i_ready   <= w_hit_go  && (r_owner == REQ_I);
            r_d_ready   <= w_hit_go  && (r_owner == REQ_D);
            r_i_miss    <= w_miss_go && (r_owner == REQ_I);
            r_d_miss    <= w_miss_go && (r_owner == REQ_D);
            r_hit_index <= w_hit_go ? w_hit_index : '0;
            r_hit_entry <= w_hit_go ? i_g_rdata[w_slot] : '0;
            r_group     <= (r_state == ST_SCAN && w_state_nxt == ST_SCAN) ? r_group + GRP_W'(1) : '0;
            if (w_grant) begin
                r_owner  <= w_grant_sel;
                r_rr_ptr <= (w_grant_sel == REQ_I) ? REQ_D : REQ_I;
                r_vpn2   <= w_grant_vpn2;
                r_asid   <= w_grant_asid;
            end
            if (w_write_go) begin
                r_cw_index <= i_cw_index;
                r_cw_entry <= i_cw_entry;
            end
        end
    end

    assign o_i_ready = r_i_ready;
    assign o_d_ready = r_d_ready;
    assign o_i_miss  = r_i_miss;
    assign o_d_miss  = r_d_miss;
    assign o_i_index = r_i_ready ? r_hit_index : '0;
    assign o_d_index = r_d_ready ? r_hit_index : '0;
    assign o_i_resp  = r_i_ready ? r_hit_entry : '0;
    assign o_d_resp  = r_d_ready ? r_hit_entry : '0;

endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// Directed bench for tlb_lookup_arbiter: behavioural entry array, hand-computed latencies.
module tb_tlb_lookup_arbiter;
    import tlb_lookup_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic i_valid, d_valid, i_ready, d_ready, i_miss, d_miss;
    logic [18:0] i_vpn2, d_vpn2;
    logic [7:0]  i_asid, d_asid;
    logic [5:0]  i_index, d_index, cw_index, a_windex, w_index;
    TLBEntry     i_resp, d_resp, cw_entry, a_wdata;
    logic        cw_req, cw_ack, a_we, w_valid;
    logic [3:0]  g_addr;
    TLBEntry [3:0] g_rdata;
    TLBEntry     mem [64];

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    int m_lat, m_rdy, m_miss, m_other, m_we, m_we_off, m_wstray;
    logic [5:0] m_idx, m_we_idx;
    TLBEntry    m_resp, m_we_data;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always_comb begin
        for (int k = 0; k < 4; k++) g_rdata[k] = mem[{g_addr, 2'(k)}];
    end

    tlb_lookup_arbiter dut (
        .clock(clock), .reset(reset),
        .i_i_valid(i_valid), .i_i_vpn2(i_vpn2), .i_i_asid(i_asid),
        .o_i_ready(i_ready), .o_i_miss(i_miss), .o_i_index(i_index), .o_i_resp(i_resp),
        .i_d_valid(d_valid), .i_d_vpn2(d_vpn2), .i_d_asid(d_asid),
        .o_d_ready(d_ready), .o_d_miss(d_miss), .o_d_index(d_index), .o_d_resp(d_resp),
        .i_cw_req(cw_req), .i_cw_index(cw_index), .i_cw_entry(cw_entry), .o_cw_ack(cw_ack),
        .o_g_addr(g_addr), .i_g_rdata(g_rdata),
        .o_a_we(a_we), .o_a_windex(a_windex), .o_a_wdata(a_wdata),
        .o_w_valid(w_valid), .o_w_index(w_index)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic TLBEntry mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                   input logic g, input logic [1:0] ps, input logic [19:0] pfn);
        TLBEntry e;
        e = '0;
        e.tag.vpn2 = vpn2;
        e.tag.asid = asid;
        e.tag.g    = g;
        e.tag.ps   = ps;
        e.pfn0     = pfn;
        e.pfn1     = pfn + 20'd1;
        e.flags0   = 5'b01011;
        return e;
    endfunction

    task automatic clear_mem();
        for (int n = 0; n < 64; n++) mem[n] = mk(19'h7FFFF, 8'hFF, 1'b0, PS4K, 20'(n));
    endtask

    // Issue one lookup at the current negedge and watch `window` cycles.
    // Optional: CP0 write raised at offset cw_at, live vpn2 swapped at chg_at, valid dropped at drop_at.
    task automatic run_req(input bit is_d, input logic [18:0] vpn2, input logic [7:0] asid,
                           input int cw_at, input logic [5:0] cw_idx, input TLBEntry cw_e,
                           input int chg_at, input logic [18:0] vpn2_b, input int drop_at,
                           input int window);
        int t0, off;
        logic rdy, ms, oth;
        m_lat = -1; m_rdy = 0; m_miss = 0; m_other = 0; m_idx = '0; m_resp = '0;
        m_we = 0; m_we_off = -1; m_we_idx = '0; m_we_data = '0; m_wstray = 0;
        t0 = cyc;
        if (is_d) begin d_valid = 1'b1; d_vpn2 = vpn2; d_asid = asid; end
        else      begin i_valid = 1'b1; i_vpn2 = vpn2; i_asid = asid; end
        if (cw_at == 0) begin cw_req = 1'b1; cw_index = cw_idx; cw_entry = cw_e; end
        for (int k = 0; k < window; k++) begin
            @(negedge clock);
            off = cyc - t0;
            rdy = is_d ? d_ready : i_ready;
            ms  = is_d ? d_miss  : i_miss;
            oth = is_d ? (i_ready | i_miss | (i_index != 6'd0) | (i_resp != '0))
                       : (d_ready | d_miss | (d_index != 6'd0) | (d_resp != '0));
            if (rdy) m_rdy++;
            if (ms)  m_miss++;
            if (oth) m_other++;
            if ((a_we != w_valid) || (a_we != cw_ack) || (a_we && (w_index != a_windex))) m_wstray++;
            if (a_we) begin
                m_we++; m_we_off = off; m_we_idx = a_windex; m_we_data = a_wdata;
                cw_req = 1'b0;
            end
            if ((rdy || ms) && m_lat < 0) begin
                m_lat  = off;
                m_idx  = is_d ? d_index : i_index;
                m_resp = is_d ? d_resp : i_resp;
                i_valid = 1'b0; d_valid = 1'b0;
            end
            if (cw_at > 0 && off == cw_at) begin cw_req = 1'b1; cw_index = cw_idx; cw_entry = cw_e; end
            if (off == chg_at) begin if (is_d) d_vpn2 = vpn2_b; else i_vpn2 = vpn2_b; end
            if (off == drop_at) begin i_valid = 1'b0; d_valid = 1'b0; end
        end
        i_valid = 1'b0; d_valid = 1'b0; cw_req = 1'b0;
    endtask

    initial begin
        int t0, off, nresp, both;
        logic [3:0] seq;
        int offs [4];
        TLBEntry we_e;

        reset = 1'b1; cw_req = 1'b0; cw_index = '0; cw_entry = '0;
        i_valid = 1'b0; i_vpn2 = '0; i_asid = '0;
        d_valid = 1'b0; d_vpn2 = '0; d_asid = '0;
        clear_mem();
        repeat (3) @(negedge clock);
        chk("rst_pulses", {i_ready, d_ready, i_miss, d_miss, cw_ack, a_we, w_valid}, 0);
        chk("rst_gaddr", g_addr, 0);
        chk("rst_index", {i_index, d_index, w_index}, 0);
        chk("rst_resp", {i_resp, d_resp}, 0);
        reset = 1'b0;
        @(negedge clock);

        // Hit at entry 37 (group 9): response 11 cycles after the grant cycle.
        mem[37] = mk(19'h12345, 8'd5, 1'b0, PS4K, 20'hA0037);
        run_req(1'b0, 19'h12345, 8'd5, -1, '0, '0, -1, '0, -1, 25);
        chk("hit37_lat", m_lat, 11);
        chk("hit37_cnt", m_rdy, 1);
        chk("hit37_nomiss", m_miss, 0);
        chk("hit37_idx", m_idx, 37);
        chk("hit37_resp", m_resp, mk(19'h12345, 8'd5, 1'b0, PS4K, 20'hA0037));
        chk("hit37_d_quiet", m_other, 0);

        // Full-array miss for d.
        run_req(1'b1, 19'h00777, 8'd3, -1, '0, '0, -1, '0, -1, 25);
        chk("miss_lat", m_lat, 17);
        chk("miss_cnt", m_miss, 1);
        chk("miss_noready", m_rdy, 0);
        chk("miss_i_quiet", m_other, 0);

        // Page-size masking at entry 8 (group 2).
        mem[8] = mk(19'h0ABC0, 8'd9, 1'b1, PS64K, 20'h00808);
        run_req(1'b0, 19'h0ABCF, 8'd2, -1, '0, '0, -1, '0, -1, 25);
        chk("ps64k_lat", m_lat, 4);
        chk("ps64k_idx", m_idx, 8);
        mem[8].tag.ps = PS16K;
        run_req(1'b0, 19'h0ABCF, 8'd2, -1, '0, '0, -1, '0, -1, 25);
        chk("ps16k_miss", {m_miss[3:0], m_rdy[3:0]}, 8'h10);
        run_req(1'b0, 19'h0ABC3, 8'd2, -1, '0, '0, -1, '0, -1, 25);
        chk("ps16k_hit_idx", m_idx, 8);
        mem[8] = mk(19'h0ABC0, 8'd9, 1'b0, PS4K, 20'h00808);
        run_req(1'b1, 19'h0ABC0, 8'd2, -1, '0, '0, -1, '0, -1, 25);
        chk("asid_miss", {m_miss[3:0], m_rdy[3:0]}, 8'h10);

        // Two matches in group 10: lowest slot wins.
        mem[41] = mk(19'h22222, 8'd1, 1'b0, PS4K, 20'h04141);
        mem[43] = mk(19'h22222, 8'd1, 1'b0, PS4K, 20'h04343);
        run_req(1'b1, 19'h22222, 8'd1, -1, '0, '0, -1, '0, -1, 25);
        chk("lowslot_lat", m_lat, 12);
        chk("lowslot_idx", m_idx, 41);
        chk("lowslot_pfn", m_resp.pfn0, 20'h04141);

        // Write and request in the same idle cycle: write first, then d is served.
        clear_mem();
        mem[1] = mk(19'h11111, 8'd1, 1'b0, PS4K, 20'h00101);
        we_e   = mk(19'h05555, 8'd4, 1'b1, PS16K, 20'h00077);
        run_req(1'b1, 19'h11111, 8'd1, 0, 6'd20, we_e, -1, '0, -1, 10);
        chk("wfirst_we_off", m_we_off, 1);
        chk("wfirst_we_cnt", m_we, 1);
        chk("wfirst_we_idx", m_we_idx, 20);
        chk("wfirst_we_data", m_we_data, we_e);
        chk("wfirst_wstray", m_wstray, 0);
        chk("wfirst_d_lat", m_lat, 4);

        // Write aborts a long i scan at scan cycle 5; i rescans and hits entry 60.
        mem[60] = mk(19'h06060, 8'd7, 1'b0, PS4K, 20'h06060);
        we_e    = mk(19'h03333, 8'd2, 1'b0, PS4K, 20'h00033);
        run_req(1'b0, 19'h06060, 8'd7, 5, 6'd3, we_e, -1, '0, -1, 30);
        chk("abort_we_off", m_we_off, 6);
        chk("abort_we_cnt", m_we, 1);
        chk("abort_we_idx", m_we_idx, 3);
        chk("abort_wstray", m_wstray, 0);
        chk("abort_i_lat", m_lat, 24);
        chk("abort_i_cnt", m_rdy, 1);
        chk("abort_i_idx", m_idx, 60);

        // Live vpn2 change mid-scan aborts; the new lookup hits entry 1.
        mem[1] = mk(19'h11111, 8'd7, 1'b0, PS4K, 20'h00101);
        run_req(1'b0, 19'h06060, 8'd7, -1, '0, '0, 3, 19'h11111, -1, 30);
        chk("chg_lat", m_lat, 6);
        chk("chg_idx", m_idx, 1);
        chk("chg_cnt", m_rdy, 1);
        run_req(1'b0, 19'h06060, 8'd7, -1, '0, '0, -1, '0, 3, 25);
        chk("drop_silent", {m_rdy[3:0], m_miss[3:0]}, 8'h00);

        // Reset during a write.
        cw_req = 1'b1; cw_index = 6'd9; cw_entry = we_e;
        @(negedge clock);
        chk("wr_before_rst", a_we, 1'b1);
        reset = 1'b1; cw_req = 1'b0;
        @(negedge clock);
        chk("wr_after_rst", {a_we, w_valid, cw_ack, w_index}, 0);
        reset = 1'b0;
        @(negedge clock);

        // Reset at scan cycle 4 after an i grant, then alternating i/d group-0 hits.
        mem[1] = mk(19'h11111, 8'd1, 1'b0, PS4K, 20'h00101);
        mem[2] = mk(19'h33333, 8'd2, 1'b0, PS4K, 20'h00202);
        i_valid = 1'b1; i_vpn2 = 19'h06060; i_asid = 8'd7;
        repeat (4) @(negedge clock);
        chk("scan_gaddr", g_addr, 3);
        reset = 1'b1; i_valid = 1'b0;
        @(negedge clock);
        chk("rst_mid_pulses", {i_ready, d_ready, i_miss, d_miss, cw_ack, a_we, w_valid}, 0);
        chk("rst_mid_gaddr", g_addr, 0);
        reset = 1'b0;
        i_valid = 1'b1; i_vpn2 = 19'h11111; i_asid = 8'd1;
        d_valid = 1'b1; d_vpn2 = 19'h33333; d_asid = 8'd2;
        t0 = cyc; nresp = 0; both = 0; seq = '0;
        for (int k = 0; k < 4; k++) offs[k] = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            off = cyc - t0;
            if (i_ready && d_ready) both++;
            if (i_ready || d_ready) begin
                if (nresp < 4) begin seq[nresp] = d_ready; offs[nresp] = off; end
                nresp++;
            end
        end
        i_valid = 1'b0; d_valid = 1'b0;
        chk("alt_seq", seq, 4'b1010);
        chk("alt_first_off", offs[0], 2);
        chk("alt_fourth_off", offs[3], 8);
        chk("alt_count", nresp, 6);
        chk("alt_no_overlap", both, 0);
        repeat (3) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
